// File: rtl/rle_flash_reader_if.sv
// Decoder-side word stream, pointer control and SPI flash pins of the RLE flash reader.
interface rle_flash_reader_if;
  logic        read_next;
  logic        stop_data;
  logic        data_ready;
  logic [15:0] data;
  logic [1:0]  save_addr;
  logic [1:0]  load_addr;
  logic        clear_addr;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  modport slave (
    input  read_next, stop_data, save_addr, load_addr, clear_addr, spi_miso,
    output data_ready, data, spi_cs_n, spi_sck, spi_mosi
  );

  modport master (
    output read_next, stop_data, save_addr, load_addr, clear_addr, spi_miso,
    input  data_ready, data, spi_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/rle_flash_reader.sv
// Streams 16-bit RLE words from a SPI flash (sequential READ, mode 0) into a 2-entry FIFO,
// with two saved read pointers so the decoder can replay a frame or a row.
module rle_flash_reader #(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]        READ_CMD   = 8'h03,
  parameter int unsigned       CS_IDLE    = 2
) (
  input logic               clk,
  input logic               rst,
  rle_flash_reader_if.slave bus
);
  localparam int unsigned TX_W   = 8 + ADDR_W;
  localparam int unsigned BIT_W  = (ADDR_W > 16) ? $clog2(ADDR_W) : 4;
  localparam int unsigned IDLE_W = (CS_IDLE > 1) ? $clog2(CS_IDLE + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA} state_e;

  state_e              state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                lead_q, lead_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic [14:0]         rx_q, rx_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [15:0]         fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]          count_q, count_d;
  logic                data_ready_q, data_ready_d;
  logic [ADDR_W-1:0]   head_q, head_d, slot0_q, slot0_d, slot1_q, slot1_d;

  logic                pop, push, restart, idle_done;
  logic [15:0]         word_in;
  logic [ADDR_W-1:0]   head_pop, fetch_addr;

  always_comb begin
    state_d      = state_q;
    cs_n_d       = cs_n_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    lead_d       = lead_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    fifo0_d      = fifo0_q;
    fifo1_d      = fifo1_q;
    count_d      = count_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    push         = 1'b0;
    pop          = bus.read_next && data_ready_q;
    restart      = bus.clear_addr || (|bus.load_addr);
    word_in      = {rx_q, bus.spi_miso};
    head_pop     = head_q + (pop ? ADDR_W'(2) : ADDR_W'(0));
    fetch_addr   = head_q + ADDR_W'({count_q, 1'b0});
    idle_done    = (32'(idle_cnt_q) + 32'd1) >= CS_IDLE;
    idle_cnt_d   = !cs_n_q ? '0 :
                   (idle_cnt_q == IDLE_W'(CS_IDLE)) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);

    // Bit engine: one low cycle (mosi set up) then one high cycle (miso sampled at its end)
    case (state_q)
      ST_IDLE: begin
        if (!bus.stop_data && idle_done) begin
          state_d          = ST_CMD;
          cs_n_d           = 1'b0;
          lead_d           = 1'b1;
          bit_cnt_d        = '0;
          {mosi_d, tx_d}   = {READ_CMD, fetch_addr, 1'b0};
        end
      end
      default: begin
        if (sck_q) begin
          sck_d          = 1'b0;
          {mosi_d, tx_d} = {tx_q, 1'b0};
          rx_d           = word_in[14:0];
          bit_cnt_d      = bit_cnt_q + BIT_W'(1);
          if (state_q == ST_CMD && bit_cnt_q == BIT_W'(7)) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
          end
          if (state_q == ST_ADDR && bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
          if (state_q == ST_DATA && bit_cnt_q == BIT_W'(15)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end
        end else if (bus.stop_data) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end else if (lead_q) begin
          lead_d = 1'b0;
        end else if (!(state_q == ST_DATA && bit_cnt_q == '0 && count_q == 2'd2)) begin
          // Withhold the next word's clocks while both entries are occupied
          sck_d = 1'b1;
        end
      end
    endcase

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) fifo0_d = word_in;
        else                 fifo1_d = word_in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        fifo0_d = fifo1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          fifo0_d = word_in;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = word_in;
        end
      end
      default: ;
    endcase

    head_d = head_pop;
    if (bus.save_addr[0]) slot0_d = head_pop;
    if (bus.save_addr[1]) slot1_d = head_pop;

    // Restart overrides everything and uses the slot values from before this cycle's save
    if (restart) begin
      state_d = ST_IDLE;
      cs_n_d  = 1'b1;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      lead_d  = 1'b0;
      count_d = 2'd0;
      head_d  = bus.clear_addr   ? START_ADDR :
                bus.load_addr[1] ? slot1_q : slot0_q;
    end

    data_ready_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cs_n_q       <= 1'b1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      lead_q       <= 1'b0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      idle_cnt_q   <= IDLE_W'(CS_IDLE);
      fifo0_q      <= '0;
      fifo1_q      <= '0;
      count_q      <= 2'd0;
      data_ready_q <= 1'b0;
      head_q       <= START_ADDR;
      slot0_q      <= START_ADDR;
      slot1_q      <= START_ADDR;
    end else begin
      state_q      <= state_d;
      cs_n_q       <= cs_n_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      lead_q       <= lead_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      idle_cnt_q   <= idle_cnt_d;
      fifo0_q      <= fifo0_d;
      fifo1_q      <= fifo1_d;
      count_q      <= count_d;
      data_ready_q <= data_ready_d;
      head_q       <= head_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
    end
  end

  assign bus.data_ready = data_ready_q;
  assign bus.data       = fifo0_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.spi_sck    = sck_q;
  assign bus.spi_mosi   = mosi_q;
endmodule

// File: tb/tb_rle_flash_reader.sv
// Bench for rle_flash_reader: SPI flash model, pointer/restart vector table, directed corner
// sequences and a randomized run checked against a head-address reference model.
module tb_rle_flash_reader;
  localparam logic [23:0] WRAP_START = 24'hFFFFFE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rle_flash_reader_if bus ();
  rle_flash_reader_if wbus ();

  rle_flash_reader #(.START_ADDR(24'h000000)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  rle_flash_reader #(.START_ADDR(WRAP_START)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'd0:   return 8'h12;
      24'd1:   return 8'h34;
      24'd2:   return 8'hAB;
      24'd3:   return 8'hCD;
      default: return 8'(a * 24'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] fword(input logic [23:0] a);
    return {fbyte(a), fbyte(a + 24'd1)};
  endfunction

  // Flash models: capture command+address on SCK rise, shift data out on SCK fall
  int unsigned bits0, fn0;
  logic [31:0] sh0;
  logic [7:0]  fb0;
  logic [31:0] log0[$];
  always @(bus.spi_sck or bus.spi_cs_n) begin
    if (bus.spi_cs_n) begin
      bits0        = 0;
      bus.spi_miso = 1'b0;
    end else if (bus.spi_sck) begin
      if (bits0 < 32) sh0 = {sh0[30:0], bus.spi_mosi};
      bits0++;
      if (bits0 == 32) log0.push_back(sh0);
    end else if (bits0 >= 32) begin
      fn0          = bits0 - 32;
      fb0          = fbyte(sh0[23:0] + 24'(fn0 / 8));
      bus.spi_miso = fb0[3'(7 - fn0 % 8)];
    end
  end

  int unsigned bits1, fn1;
  logic [31:0] sh1;
  logic [7:0]  fb1;
  logic [31:0] log1[$];
  always @(wbus.spi_sck or wbus.spi_cs_n) begin
    if (wbus.spi_cs_n) begin
      bits1         = 0;
      wbus.spi_miso = 1'b0;
    end else if (wbus.spi_sck) begin
      if (bits1 < 32) sh1 = {sh1[30:0], wbus.spi_mosi};
      bits1++;
      if (bits1 == 32) log1.push_back(sh1);
    end else if (bits1 >= 32) begin
      fn1           = bits1 - 32;
      fb1           = fbyte(sh1[23:0] + 24'(fn1 / 8));
      wbus.spi_miso = fb1[3'(7 - fn1 % 8)];
    end
  end

  // Reference model: the word at data is always the flash word at the head address
  logic [23:0] m_head, m_slot0, m_slot1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs from a negedge, update the model, return at the next negedge
  task automatic cyc(input logic rn, input logic [1:0] sv, input logic [1:0] ld, input logic clr);
    logic [23:0] nh;
    bus.read_next  = rn;
    bus.save_addr  = sv;
    bus.load_addr  = ld;
    bus.clear_addr = clr;
    nh = m_head + ((rn && bus.data_ready) ? 24'd2 : 24'd0);
    if (clr)        m_head = 24'h000000;
    else if (ld[1]) m_head = m_slot1;
    else if (ld[0]) m_head = m_slot0;
    else            m_head = nh;
    if (sv[0]) m_slot0 = nh;
    if (sv[1]) m_slot1 = nh;
    @(posedge clk);
    @(negedge clk);
    bus.read_next  = 1'b0;
    bus.save_addr  = 2'b00;
    bus.load_addr  = 2'b00;
    bus.clear_addr = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.data_ready && n < 400) begin cyc(1'b0, 2'b00, 2'b00, 1'b0); n++; end
    if (!bus.data_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop();
    wait_ready();
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (log0.size() == 0 && n < 400) begin cyc(1'b0, 2'b00, 2'b00, 1'b0); n++; end
    if (log0.size() == 0) begin
      check("cmd_timeout", 32'd0, 32'd1);
      log0.push_back(32'hFFFF_FFFF);
    end
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  sv;
    logic        sv_pop;
    int          post;
    logic        clr;
    logic [1:0]  ld;
    logic [23:0] exp_addr;
  } vec_t;

  vec_t vecs[5];
  int   lat, n, stop_run, pops;
  logic rn_r, clr_r;
  logic [1:0] sv_r, ld_r;

  initial begin
    vecs[0] = '{5, 2'b10, 1'b1, 3, 1'b0, 2'b10, 24'h00000C};
    vecs[1] = '{2, 2'b01, 1'b0, 4, 1'b0, 2'b01, 24'h000010};
    vecs[2] = '{3, 2'b11, 1'b1, 2, 1'b1, 2'b11, 24'h000000};
    vecs[3] = '{1, 2'b01, 1'b0, 1, 1'b0, 2'b11, 24'h000018};
    vecs[4] = '{4, 2'b10, 1'b1, 0, 1'b0, 2'b01, 24'h000002};

    bus.read_next = 1'b0;  bus.stop_data = 1'b0;  bus.save_addr = 2'b00;
    bus.load_addr = 2'b00; bus.clear_addr = 1'b0;
    wbus.read_next = 1'b0; wbus.stop_data = 1'b0; wbus.save_addr = 2'b00;
    wbus.load_addr = 2'b00; wbus.clear_addr = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("rst_sck", 32'(bus.spi_sck), 32'd0);
    check("rst_mosi", 32'(bus.spi_mosi), 32'd0);
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);

    // First word latency from reset release, command bytes and first two words
    m_head = 24'd0; m_slot0 = 24'd0; m_slot1 = 24'd0;
    rst = 1'b0;
    lat = 0;
    while (!bus.data_ready && lat < 200) begin cyc(1'b0, 2'b00, 2'b00, 1'b0); lat++; end
    check("first_latency", 32'(lat), 32'd98);
    wait_cmd();
    check("first_cmd", log0[0], 32'h03000000);
    check("first_data", 32'(bus.data), 32'h1234);

    // No pops: two words buffered, clocks paused with CS held low
    repeat (60) cyc(1'b0, 2'b00, 2'b00, 1'b0);
    check("pause_pulses", 32'(bits0), 32'd64);
    check("pause_cs_n", 32'(bus.spi_cs_n), 32'd0);
    check("pause_sck", 32'(bus.spi_sck), 32'd0);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
    check("pop1_data", 32'(bus.data), 32'hABCD);
    repeat (60) cyc(1'b0, 2'b00, 2'b00, 1'b0);
    check("resume_pulses", 32'(bits0), 32'd80);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
    check("pop2_data", 32'(bus.data), 32'(fword(24'd4)));

    // Save/load/clear vector table
    cyc(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].pre) pop();
      wait_ready();
      cyc(vecs[i].sv_pop, vecs[i].sv, 2'b00, 1'b0);
      repeat (vecs[i].post) pop();
      log0.delete();
      cyc(1'b0, 2'b00, vecs[i].ld, vecs[i].clr);
      check($sformatf("vec%0d_ready_low", i), 32'(bus.data_ready), 32'd0);
      check($sformatf("vec%0d_cs_n", i), 32'(bus.spi_cs_n), 32'd1);
      wait_cmd();
      check($sformatf("vec%0d_addr", i), log0[0], {8'h03, vecs[i].exp_addr});
      wait_ready();
      check($sformatf("vec%0d_data", i), 32'(bus.data), 32'(fword(vecs[i].exp_addr)));
    end

    // stop_data mid-word: buffered word stays poppable, refetch from head+2*count
    cyc(1'b0, 2'b00, 2'b00, 1'b1);
    wait_ready();
    n = 0;
    while (bits0 < 56 && n < 100) begin cyc(1'b0, 2'b00, 2'b00, 1'b0); n++; end
    bus.stop_data = 1'b1;
    repeat (3) cyc(1'b0, 2'b00, 2'b00, 1'b0);
    check("stop_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("stop_ready", 32'(bus.data_ready), 32'd1);
    check("stop_data", 32'(bus.data), 32'h1234);
    cyc(1'b1, 2'b00, 2'b00, 1'b0);
    repeat (6) cyc(1'b0, 2'b00, 2'b00, 1'b0);
    check("stop_pop_empty", 32'(bus.data_ready), 32'd0);
    log0.delete();
    bus.stop_data = 1'b0;
    wait_cmd();
    check("stop_refetch_addr", log0[0], 32'h03000002);
    wait_ready();
    check("stop_refetch_data", 32'(bus.data), 32'hABCD);

    // Address wrap on the second instance
    check("wrap_first_addr", log1[0], {8'h03, WRAP_START});
    check("wrap_first_data", 32'(wbus.data), 32'(fword(WRAP_START)));
    wbus.clear_addr = 1'b1;
    @(negedge clk);
    wbus.clear_addr = 1'b0;
    n = 0;
    while (!wbus.data_ready && n < 400) begin @(negedge clk); n++; end
    check("wrap_ready", 32'(wbus.data_ready), 32'd1);
    wbus.stop_data = 1'b1;
    repeat (4) @(negedge clk);
    check("wrap_stop_cs_n", 32'(wbus.spi_cs_n), 32'd1);
    wbus.read_next = 1'b1;
    @(negedge clk);
    wbus.read_next = 1'b0;
    check("wrap_pop_empty", 32'(wbus.data_ready), 32'd0);
    log1.delete();
    wbus.stop_data = 1'b0;
    n = 0;
    while ((log1.size() == 0 || !wbus.data_ready) && n < 400) begin @(negedge clk); n++; end
    if (log1.size() == 0) log1.push_back(32'hFFFF_FFFF);
    check("wrap_refetch_addr", log1[0], 32'h03000000);
    check("wrap_refetch_data", 32'(wbus.data), 32'h1234);

    // Randomized run against the head-address model
    pops = 0;
    stop_run = 0;
    for (int i = 0; i < 6000; i++) begin
      if (bus.data_ready) check("rand_data", 32'(bus.data), 32'(fword(m_head)));
      if (stop_run > 0) stop_run--;
      else if ($urandom_range(99) == 0) stop_run = $urandom_range(20, 1);
      bus.stop_data = (stop_run > 0);
      rn_r  = 1'($urandom_range(1));
      sv_r  = ($urandom_range(19) == 0) ? 2'($urandom_range(3)) : 2'b00;
      ld_r  = ($urandom_range(199) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      clr_r = ($urandom_range(499) == 0);
      if (rn_r && bus.data_ready) pops++;
      cyc(rn_r, sv_r, ld_r, clr_r);
    end
    bus.stop_data = 1'b0;
    check("rand_progress", 32'(pops >= 10), 32'd1);

    // Asynchronous reset in the middle of the address phase
    cyc(1'b0, 2'b00, 2'b00, 1'b1);
    n = 0;
    while (!(bits0 >= 12 && bits0 < 28) && n < 100) begin cyc(1'b0, 2'b00, 2'b00, 1'b0); n++; end
    check("mid_addr_reached", 32'(bus.spi_cs_n), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
    check("async_rst_sck", 32'(bus.spi_sck), 32'd0);
    check("async_rst_ready", 32'(bus.data_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
